// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide DRAM port between the host loader (r0) and the Control_Unit (r1).
// Optional owner lock that suppresses the burst-cap handover is enabled by defining ARB_LOCK_EN.
module dram_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  SYNC_RST,
    input  logic                  r0_req,
    input  logic                  r0_wren,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wrdata,
`ifdef ARB_LOCK_EN
    input  logic                  r0_lock,
`endif
    output logic                  r0_gnt,
    output logic                  r0_rdvalid,
    input  logic                  r1_req,
    input  logic                  r1_wren,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wrdata,
`ifdef ARB_LOCK_EN
    input  logic                  r1_lock,
`endif
    output logic                  r1_gnt,
    output logic                  r1_rdvalid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  dram_en,
    output logic                  dram_wren,
    output logic [ADDR_WIDTH-1:0] dram_wraddr,
    output logic [DATA_WIDTH-1:0] dram_wrdata,
    output logic [ADDR_WIDTH-1:0] dram_rdaddr,
    input  logic [DATA_WIDTH-1:0] dram_rddata
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_OWN0     = 2'd1;
    localparam logic [1:0] ST_OWN1     = 2'd2;
    localparam logic [1:0] ST_HANDOVER = 2'd3;

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic                  ptr_r;
    logic                  ptr_nxt_s;
    logic                  prev_r;
    logic                  prev_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic                  r0_gnt_r;
    logic                  r1_gnt_r;
    logic [RD_LATENCY-1:0] rd0_vld_r;
    logic [RD_LATENCY-1:0] rd1_vld_r;

    logic                  r0_lock_s;
    logic                  r1_lock_s;
    logic                  own_is1_s;
    logic                  own_req_s;
    logic                  oth_req_s;
    logic                  own_lock_s;
    logic                  issue_s;
    logic                  issue_id_s;

`ifdef ARB_LOCK_EN
    assign r0_lock_s = r0_lock;
    assign r1_lock_s = r1_lock;
`else
    assign r0_lock_s = 1'b0;
    assign r1_lock_s = 1'b0;
`endif

    // Owner/other view of the request lines, used only while in an OWN state.
    assign own_is1_s  = (state_r == ST_OWN1);
    assign own_req_s  = own_is1_s ? r1_req    : r0_req;
    assign oth_req_s  = own_is1_s ? r0_req    : r1_req;
    assign own_lock_s = own_is1_s ? r1_lock_s : r0_lock_s;

    assign r0_gnt     = r0_gnt_r;
    assign r1_gnt     = r1_gnt_r;
    assign r0_rdvalid = rd0_vld_r[RD_LATENCY-1];
    assign r1_rdvalid = rd1_vld_r[RD_LATENCY-1];
    assign rd_data    = dram_rddata;

    // Next-state, round-robin pointer and burst-cap counter.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        prev_nxt_s  = prev_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (r0_req && r1_req) begin
                    state_nxt_s = ptr_r ? ST_OWN1 : ST_OWN0;
                end else if (r0_req) begin
                    state_nxt_s = ST_OWN0;
                end else if (r1_req) begin
                    state_nxt_s = ST_OWN1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!own_req_s) begin
                    // Voluntary release hands straight over with no dead cycle.
                    state_nxt_s = oth_req_s ? (own_is1_s ? ST_OWN0 : ST_OWN1) : ST_IDLE;
                    ptr_nxt_s   = ~own_is1_s;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (oth_req_s && !own_lock_s && (cnt_r == CNT_LAST)) begin
                    state_nxt_s = ST_HANDOVER;
                    ptr_nxt_s   = ~own_is1_s;
                    prev_nxt_s  = own_is1_s;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (!oth_req_s) begin
                    cnt_nxt_s   = CNT_ZERO;
                end else if (own_lock_s) begin
                    cnt_nxt_s   = cnt_r;
                end else if (cnt_r != CNT_LAST) begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end else begin
                    cnt_nxt_s   = cnt_r;
                end
            end
            ST_HANDOVER: begin
                if (ptr_r ? r1_req : r0_req) begin
                    state_nxt_s = ptr_r ? ST_OWN1 : ST_OWN0;
                end else if (prev_r ? r1_req : r0_req) begin
                    state_nxt_s = prev_r ? ST_OWN1 : ST_OWN0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Arbitration state and registered grants.
    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            state_r  <= ST_IDLE;
            ptr_r    <= 1'b0;
            prev_r   <= 1'b0;
            cnt_r    <= CNT_ZERO;
            r0_gnt_r <= 1'b0;
            r1_gnt_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            ptr_r    <= ptr_nxt_s;
            prev_r   <= prev_nxt_s;
            cnt_r    <= cnt_nxt_s;
            r0_gnt_r <= (state_nxt_s == ST_OWN0);
            r1_gnt_r <= (state_nxt_s == ST_OWN1);
        end
    end

    // DRAM port steering from the current owner's request.
    always_comb begin
        issue_s     = 1'b0;
        issue_id_s  = 1'b0;
        dram_en     = 1'b0;
        dram_wren   = 1'b0;
        dram_wraddr = {ADDR_WIDTH{1'b0}};
        dram_rdaddr = {ADDR_WIDTH{1'b0}};
        dram_wrdata = {DATA_WIDTH{1'b0}};
        if (r0_gnt_r && r0_req) begin
            issue_s     = 1'b1;
            issue_id_s  = 1'b0;
            dram_en     = 1'b1;
            dram_wren   = r0_wren;
            dram_wraddr = r0_addr;
            dram_rdaddr = r0_addr;
            dram_wrdata = r0_wrdata;
        end else if (r1_gnt_r && r1_req) begin
            issue_s     = 1'b1;
            issue_id_s  = 1'b1;
            dram_en     = 1'b1;
            dram_wren   = r1_wren;
            dram_wraddr = r1_addr;
            dram_rdaddr = r1_addr;
            dram_wrdata = r1_wrdata;
        end else begin
            issue_s     = 1'b0;
        end
    end

    // Read-return tag pipeline, one-hot per requester so the valids come straight from flops.
    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            rd0_vld_r <= {RD_LATENCY{1'b0}};
            rd1_vld_r <= {RD_LATENCY{1'b0}};
        end else begin
            rd0_vld_r[0] <= issue_s && !dram_wren && !issue_id_s;
            rd1_vld_r[0] <= issue_s && !dram_wren &&  issue_id_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd0_vld_r[i] <= rd0_vld_r[i-1];
                rd1_vld_r[i] <= rd1_vld_r[i-1];
            end
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: directed scenarios followed by random traffic,
// all compared against an ownership-level reference model and a behavioural DRAM.
module tb_dram_port_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int MB  = 4;
    localparam int LAT = 2;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          SYNC_RST;
    logic          t_req  [2];
    logic          t_wren [2];
    logic [AW-1:0] t_addr [2];
    logic [DW-1:0] t_data [2];
    logic          t_lock [2];
    logic          r0_gnt, r1_gnt, r0_rdvalid, r1_rdvalid;
    logic [DW-1:0] rd_data, dram_wrdata, dram_rddata;
    logic          dram_en, dram_wren;
    logic [AW-1:0] dram_wraddr, dram_rdaddr;

    dram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .RD_LATENCY(LAT)) dut (
        .CLK(CLK), .SYNC_RST(SYNC_RST),
        .r0_req(t_req[0]), .r0_wren(t_wren[0]), .r0_addr(t_addr[0]), .r0_wrdata(t_data[0]),
`ifdef ARB_LOCK_EN
        .r0_lock(t_lock[0]),
`endif
        .r0_gnt(r0_gnt), .r0_rdvalid(r0_rdvalid),
        .r1_req(t_req[1]), .r1_wren(t_wren[1]), .r1_addr(t_addr[1]), .r1_wrdata(t_data[1]),
`ifdef ARB_LOCK_EN
        .r1_lock(t_lock[1]),
`endif
        .r1_gnt(r1_gnt), .r1_rdvalid(r1_rdvalid),
        .rd_data(rd_data), .dram_en(dram_en), .dram_wren(dram_wren),
        .dram_wraddr(dram_wraddr), .dram_wrdata(dram_wrdata),
        .dram_rdaddr(dram_rdaddr), .dram_rddata(dram_rddata)
    );

    // Behavioural DRAM: synchronous write, read data LAT cycles after issue.
    logic [DW-1:0] mem   [256];
    logic [DW-1:0] rpipe [LAT];
    logic          init_mem;
    int            en_cnt = 0;
    assign dram_rddata = rpipe[LAT-1];
    always @(posedge CLK) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i ^ 8'hA5);
        end else if (dram_en && dram_wren) begin
            mem[dram_wraddr] <= dram_wrdata;
        end
        rpipe[0] <= (dram_en && !dram_wren) ? mem[dram_rdaddr] : 8'h00;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
        if (dram_en) en_cnt <= en_cnt + 1;
    end

    // Reference model: who owns the port, whose turn is next, and pending read returns.
    typedef struct { int due; int id; logic [DW-1:0] data; } rd_t;
    rd_t           rq[$];
    logic [DW-1:0] ref_mem [256];
    int            m_owner, m_turn, m_prev, m_run, cyc;
    bit            m_dead;
    bit            m_iss [2];
    int            checks, errors;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(int r, bit rq_v, bit wr, int a, int d);
        t_req[r]  = rq_v;
        t_wren[r] = wr;
        t_addr[r] = 8'(a);
        t_data[r] = 8'(d);
    endtask

    task automatic tick(bit do_chk);
        int   o, oth;
        bit   iss, lk, ev0, ev1;
        logic [DW-1:0] edata;
        rd_t  e;
        #1;
        o   = m_owner;
        iss = 1'b0;
        if (!m_dead && o >= 0) iss = t_req[o];
        ev0 = 1'b0; ev1 = 1'b0; edata = 8'h00;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e = rq.pop_front();
            if (e.id == 0) ev0 = 1'b1; else ev1 = 1'b1;
            edata = e.data;
        end
        if (do_chk) begin
            chk("r0_gnt", 32'(r0_gnt), 32'(!m_dead && o == 0));
            chk("r1_gnt", 32'(r1_gnt), 32'(!m_dead && o == 1));
            chk("gnt_mutex", 32'(r0_gnt & r1_gnt), 32'd0);
            chk("dram_en", 32'(dram_en), 32'(iss));
            chk("dram_wren", 32'(dram_wren), iss ? 32'(t_wren[o]) : 32'd0);
            chk("dram_wraddr", 32'(dram_wraddr), iss ? 32'(t_addr[o]) : 32'd0);
            chk("dram_rdaddr", 32'(dram_rdaddr), iss ? 32'(t_addr[o]) : 32'd0);
            chk("dram_wrdata", 32'(dram_wrdata), iss ? 32'(t_data[o]) : 32'd0);
            chk("r0_rdvalid", 32'(r0_rdvalid), 32'(ev0));
            chk("r1_rdvalid", 32'(r1_rdvalid), 32'(ev1));
            if (ev0 || ev1) chk("rd_data", 32'(rd_data), 32'(edata));
        end
        m_iss[0] = iss && (o == 0);
        m_iss[1] = iss && (o == 1);
        if (iss) begin
            if (t_wren[o]) begin
                ref_mem[t_addr[o]] = t_data[o];
            end else begin
                e.due = cyc + LAT; e.id = o; e.data = ref_mem[t_addr[o]];
                rq.push_back(e);
            end
        end
        if (m_dead) begin
            m_dead = 1'b0;
            if (t_req[m_turn]) m_owner = m_turn;
            else if (t_req[m_prev]) m_owner = m_prev;
            else m_owner = -1;
        end else if (o < 0) begin
            if (t_req[0] && t_req[1]) m_owner = m_turn;
            else if (t_req[0]) m_owner = 0;
            else if (t_req[1]) m_owner = 1;
            else m_owner = -1;
            m_run = 0;
        end else begin
            oth = 1 - o;
`ifdef ARB_LOCK_EN
            lk = t_lock[o];
`else
            lk = 1'b0;
`endif
            if (!t_req[o]) begin
                m_owner = t_req[oth] ? oth : -1; m_turn = oth; m_run = 0;
            end else if (t_req[oth] && !lk && m_run + 1 >= MB) begin
                m_dead = 1'b1; m_prev = o; m_owner = -1; m_turn = oth; m_run = 0;
            end else if (!t_req[oth]) begin
                m_run = 0;
            end else if (!lk) begin
                m_run++;
            end
        end
        if (SYNC_RST) begin
            m_owner = -1; m_dead = 1'b0; m_turn = 0; m_run = 0; rq.delete();
        end
        cyc++;
        @(negedge CLK);
    endtask

    initial begin
        int base;
        checks = 0; errors = 0; cyc = 0;
        m_owner = -1; m_dead = 1'b0; m_turn = 0; m_prev = 0; m_run = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i ^ 8'hA5);
        for (int r = 0; r < 2; r++) begin drive(r, 0, 0, 0, 0); t_lock[r] = 1'b0; m_iss[r] = 1'b0; end
        SYNC_RST = 1'b1; init_mem = 1'b1;
        @(negedge CLK);
        tick(1'b0);
        init_mem = 1'b0;
        tick(1'b1);
        SYNC_RST = 1'b0;
        tick(1'b1);

        // Single requester: 16 writes, data = addr.
        drive(0, 1, 1, 0, 0);
        tick(1'b1);
        base = en_cnt;
        for (int i = 0; i < 16; i++) begin drive(0, 1, 1, i, i); tick(1'b1); end
        drive(0, 0, 0, 0, 0);
        tick(1'b1); tick(1'b1);
        chk("single_en_pulses", 32'(en_cnt - base), 32'd16);

        // Contention from reset, pointer at 0.
        SYNC_RST = 1'b1; tick(1'b1); SYNC_RST = 1'b0;
        for (int i = 0; i < 22; i++) begin
            drive(0, 1, 1, 8'h40 + i, 8'h80 + i);
            drive(1, 1, 0, 8'h60 + i, 0);
            tick(1'b1);
        end
        drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
        tick(1'b1); tick(1'b1); tick(1'b1);

        // Read tagging, with early release handing over without a dead cycle.
        drive(0, 1, 1, 8'h23, 8'h05); tick(1'b1); tick(1'b1);
        drive(0, 0, 0, 0, 0); drive(1, 1, 0, 8'h23, 0); tick(1'b1);
        tick(1'b1);
        drive(1, 0, 0, 0, 0); drive(0, 1, 0, 8'h10, 0); tick(1'b1);
        tick(1'b1); tick(1'b1);
        drive(0, 0, 0, 0, 0); tick(1'b1); tick(1'b1); tick(1'b1);

        // Reset mid-burst with reads in flight.
        drive(0, 1, 0, 8'h30, 0); drive(1, 1, 1, 8'h31, 8'h77);
        tick(1'b1); tick(1'b1); tick(1'b1);
        SYNC_RST = 1'b1; tick(1'b1); SYNC_RST = 1'b0;
        drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
        for (int i = 0; i < LAT + 2; i++) tick(1'b1);

`ifdef ARB_LOCK_EN
        // Locked owner keeps the port beyond the burst cap.
        SYNC_RST = 1'b1; tick(1'b1); SYNC_RST = 1'b0;
        t_lock[0] = 1'b1;
        drive(1, 1, 1, 8'h90, 8'h11);
        for (int i = 0; i < 11; i++) begin drive(0, 1, 1, 8'hA0 + i, i); tick(1'b1); end
        t_lock[0] = 1'b0; drive(0, 0, 0, 0, 0);
        tick(1'b1); tick(1'b1); tick(1'b1);
        drive(1, 0, 0, 0, 0); tick(1'b1);
`endif

        // Random traffic; requests held until issued, occasionally abandoned.
        for (int n = 0; n < 500; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!t_req[r] || m_iss[r]) begin
                    drive(r, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 15), $urandom_range(0, 255));
                    t_lock[r] = ($urandom_range(0, 3) == 0);
                end else if ($urandom_range(0, 15) == 0) begin
                    t_req[r] = 1'b0;
                end
            end
            SYNC_RST = ($urandom_range(0, 99) == 0);
            tick(1'b1);
        end
        SYNC_RST = 1'b0;
        drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
        for (int i = 0; i < LAT + 3; i++) tick(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single byte-wide DRAM port between two requesters: requester 0 is the test/host loader and requester 1 is the Control_Unit.
- Replaces the static `test ? ... : ...` steering mux in front of the DRAM.
- Round-robin arbitration with registered grants.
- A burst cap bounds how long one requester can hold the port.
- Read data is tagged so only the issuing requester sees a read-valid.

Parameters:
- ADDR_WIDTH, 8, DRAM byte address width (DRAM word address plus byte offset).
- DATA_WIDTH, 8, byte lane width.
- MAX_BURST, 16, maximum consecutive granted accesses while the other requester waits; must be >= 1.
- RD_LATENCY, 1, DRAM cycles from read issue to rddata valid; must be >= 1.

Ports:
- CLK  in  1  clock, rising edge.
- SYNC_RST  in  1  reset, synchronous, active-high.
- r0_req  in  1  requester 0 wants an access this cycle.
- r0_wren  in  1  1 = write, 0 = read.
- r0_addr  in  ADDR_WIDTH  access address.
- r0_wrdata  in  DATA_WIDTH  write data.
- r0_gnt  out  1  requester 0 owns the port.
- r0_rdvalid  out  1  rd_data holds requester 0 read data.
- r1_req, r1_wren, r1_addr, r1_wrdata, r1_gnt, r1_rdvalid: same as above, for requester 1.
- rd_data  out  DATA_WIDTH  DRAM rddata passthrough.
- dram_en  out  1  DRAM enable.
- dram_wren  out  1  DRAM write enable.
- dram_wraddr  out  ADDR_WIDTH  DRAM write address.
- dram_wrdata  out  DATA_WIDTH  DRAM write data.
- dram_rdaddr  out  ADDR_WIDTH  DRAM read address.
- dram_rddata  in  DATA_WIDTH  DRAM read data.

Behaviour:
- Reset values:
  - State IDLE; priority pointer = 0; burst_cnt = 0.
  - r0_gnt = r1_gnt = 0; rdvalid pipeline cleared.
  - dram_en = dram_wren = 0; dram address/data outputs = 0.
- Reset mid-operation:
  - All in-flight read tags are dropped; no rdvalid is asserted after reset.
  - The DRAM contents are not touched.
- FSM states: IDLE, OWN0, OWN1, HANDOVER.
- Grant outputs: r0_gnt = (state==OWN0); r1_gnt = (state==OWN1). Both are registered and mutually exclusive.
- Issue rule: an access is issued in any cycle where rX_gnt && rX_req.
  - dram_en = 1.
  - dram_wren = rX_wren.
  - dram_wraddr and dram_rdaddr = rX_addr.
  - dram_wrdata = rX_wrdata.
  - Otherwise dram_en = dram_wren = 0 and addresses/data = 0. This output path is combinational from state and the owner's inputs.
- IDLE transitions:
  - If exactly one req is high, go to that requester's OWN state.
  - If both are high, go to OWN[pointer].
  - If neither is high, stay in IDLE.
  - First access is therefore issued one cycle after req rises.
- OWNx transitions, evaluated each cycle:
  - If rX_req = 0: go to OWN[other] if the other req is high, else IDLE. Set pointer = other; burst_cnt = 0.
  - Else if the other req is high and burst_cnt == MAX_BURST-1 (this cycle's access is the last allowed): go to HANDOVER. Set pointer = other; burst_cnt = 0.
  - Else stay. burst_cnt increments only while the other req is high and saturates; it is cleared when the other req is low.
- HANDOVER:
  - One dead cycle; no grant.
  - Next state is OWN[pointer] if that req is high; else OWN[previous owner] if its req is high; else IDLE.
- Read return:
  - A RD_LATENCY-deep shift register carries {valid, id} for each issued read.
  - rX_rdvalid = 1 exactly RD_LATENCY cycles after the issue cycle, with rd_data = dram_rddata.
  - Reads in flight across a grant change are still returned to the issuer.
- Write-then-read to the same address across requesters: ordering equals issue order; the DRAM resolves it, and the arbiter adds no forwarding.
- Requesters must hold req/wren/addr/wrdata stable until they see gnt. Dropping req before gnt is legal (the request is abandoned).

Optional Feature:
- Macro: ARB_LOCK_EN.
- With the macro defined:
  - Adds inputs r0_lock and r1_lock (1 bit each).
  - While the owner holds rX_lock && rX_req, the MAX_BURST handover is suppressed, so the owner keeps the port until req or lock drops. burst_cnt freezes.
  - Used by the loader for atomic multi-byte DRAM word writes.
- Without the macro: the ports are absent and MAX_BURST always applies.

Test Plan:
- Reset: assert SYNC_RST mid-burst with a read in flight -> next cycle both gnt = 0, dram_en = 0, and no rdvalid for the in-flight read.
- Single requester: r0 writes addr 0x00..0x0F with data = addr, while r1_req = 0 -> r0_gnt rises 1 cycle after req; 16 consecutive dram_en pulses with dram_wraddr = dram_wrdata = 0..15; no HANDOVER.
- Contention with MAX_BURST = 4: both req held from IDLE with pointer = 0 -> sequence OWN0 ×4 accesses, HANDOVER ×1, OWN1 ×4 accesses, HANDOVER, OWN0 …; gnt is never high for both.
- Read tagging: r1 reads addr 0x23 while DRAM holds 0x05, then ownership switches to r0 -> r1_rdvalid = 1 and rd_data = 0x05 exactly RD_LATENCY cycles after issue; r0_rdvalid stays 0.
- Early release: r0 owns and drops req while r1_req = 1 -> next cycle r1_gnt = 1 with no dead cycle; pointer = 1.
- ARB_LOCK_EN defined, MAX_BURST = 4: r0 holds lock for 10 writes while r1 requests -> 10 uninterrupted r0 accesses, then r1 is granted.
